axis_sa_feeder: RTL and testbench

//  Transmit side of the systolic-array input stream. Joins an X stream (R values/beat) and a
//  K stream (C values/beat) into the single lock-step beat stream the array consumes, adding last

---
 rtl/axis_sa_pkg.sv | 21 ++
 rtl/axis_skid_fifo.sv | 74 +++++++
 rtl/axis_sa_feeder.sv | 172 +++++++++++++++++
 tb/tb_axis_sa_feeder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_sa_pkg.sv
// Shared types and constants for the systolic-array input feeder.
// Optional feature macro: SA_FEEDER_LAST_CHECK_EN (adds a last-flag bit to each buffered beat).
package axis_sa_pkg;

    localparam int SA_R  = 4;   // rows; X values per beat
    localparam int SA_C  = 8;   // columns; K values per beat
    localparam int SA_WX = 4;   // X element width
    localparam int SA_WK = 8;   // K element width
    localparam int SA_WL = 16;  // accumulation length / beat counter width

    typedef logic [SA_R-1:0][SA_WX-1:0] x_beat_t;
    typedef logic [SA_C-1:0][SA_WK-1:0] k_beat_t;

    // Width of the per-beat last flag carried through the skid FIFOs.
`ifdef SA_FEEDER_LAST_CHECK_EN
    localparam int SA_LAST_W = 1;
`else
    localparam int SA_LAST_W = 0;
`endif

endpackage

// File: rtl/axis_skid_fifo.sv
// Two-entry fall-through skid FIFO with a registered ready.
// When empty, an incoming beat is presented on o_data in the same cycle and can be
// popped straight through without being stored; otherwise the head entry is presented.
// Handshake: a beat is accepted on a rising edge where i_valid && o_ready. o_ready is a
// register equal to "not full", so no combinational path exists from i_pop to o_ready.
module axis_skid_fifo
#(
    parameter int W = 8
)
(
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_avail,
    output logic [W-1:0] o_data,
    input  logic         i_pop
);

    logic [W-1:0] r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_cnt;
    logic         r_ready;

    logic         w_push;
    logic         w_bypass;
    logic         w_store;
    logic         w_take;
    logic         w_empty;
    logic [1:0]   w_cnt_next;

    // Decode push/pop into store-to-memory, bypass and take-from-memory actions.
    always_comb begin
        w_empty    = (r_cnt == 2'd0);
        w_push     = i_valid && r_ready;
        w_bypass   = i_pop && w_empty;
        w_store    = w_push && !w_bypass;
        w_take     = i_pop && !w_empty;
        w_cnt_next = r_cnt + {1'b0, w_store} - {1'b0, w_take};
    end

    assign o_avail = !w_empty || w_push;
    assign o_data  = w_empty ? i_data : r_mem[r_rptr];
    assign o_ready = r_ready;

    // Occupancy, pointers and registered ready (ready is low while in reset).
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt   <= 2'd0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_ready <= (w_cnt_next != 2'd2);
            if (w_store) begin
                r_wptr <= ~r_wptr;
            end
            if (w_take) begin
                r_rptr <= ~r_rptr;
            end
        end
    end

    // Storage array; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wptr] <= i_data;
        end
    end

endmodule

// File: rtl/axis_sa_feeder.sv
// Joins the X and K streams into one lock-step beat stream for the systolic array and
// marks the last beat of every accumulation of cfg_k_len beats (0 behaves as 1).
// Optional feature macro: SA_FEEDER_LAST_CHECK_EN adds sx_last/sk_last inputs and a
// sticky err_last output that flags input last markers disagreeing with the counter.
// Handshake: every stream transfers on a rising edge where valid && ready; the output
// holds m_valid, m_last and data stable until m_ready, and never drops m_valid without a
// transfer. Input readies are registered and never depend on m_ready combinationally.
module axis_sa_feeder
    import axis_sa_pkg::*;
#(
    parameter int R  = SA_R,
    parameter int C  = SA_C,
    parameter int WX = SA_WX,
    parameter int WK = SA_WK,
    parameter int WL = SA_WL
)
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [WL-1:0]         cfg_k_len,
    input  logic                  sx_valid,
    output logic                  sx_ready,
    input  logic [R-1:0][WX-1:0]  sx_data,
    input  logic                  sk_valid,
    output logic                  sk_ready,
    input  logic [C-1:0][WK-1:0]  sk_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [R-1:0][WX-1:0]  mx_data,
    output logic [C-1:0][WK-1:0]  mk_data,
    output logic                  busy,
`ifdef SA_FEEDER_LAST_CHECK_EN
    input  logic                  sx_last,
    input  logic                  sk_last,
    output logic                  err_last,
`endif
    output logic                  tile_done
);

    localparam int XW = R * WX + SA_LAST_W;
    localparam int KW = C * WK + SA_LAST_W;

    logic [XW-1:0]         w_x_in;
    logic [XW-1:0]         w_x_head;
    logic                  w_x_avail;
    logic [KW-1:0]         w_k_in;
    logic [KW-1:0]         w_k_head;
    logic                  w_k_avail;

    logic                  w_load;
    logic                  w_xfer;
    logic [WL-1:0]         w_len_eff;
    logic                  w_is_last;
    logic [WL-1:0]         w_beat_next;

    logic                  r_m_valid;
    logic                  r_m_last;
    logic [R-1:0][WX-1:0]  r_mx;
    logic [C-1:0][WK-1:0]  r_mk;
    logic [WL-1:0]         r_beat_cnt;
    logic [WL-1:0]         r_len_q;
    logic                  r_tile_done;

`ifdef SA_FEEDER_LAST_CHECK_EN
    logic                  w_flag_err;
    logic                  r_err_last;

    assign w_x_in = {sx_last, sx_data};
    assign w_k_in = {sk_last, sk_data};
`else
    assign w_x_in = sx_data;
    assign w_k_in = sk_data;
`endif

    axis_skid_fifo #(.W(XW)) u_x_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_valid (sx_valid),
        .o_ready (sx_ready),
        .i_data  (w_x_in),
        .o_avail (w_x_avail),
        .o_data  (w_x_head),
        .i_pop   (w_load)
    );

    axis_skid_fifo #(.W(KW)) u_k_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_valid (sk_valid),
        .o_ready (sk_ready),
        .i_data  (w_k_in),
        .o_avail (w_k_avail),
        .o_data  (w_k_head),
        .i_pop   (w_load)
    );

    // Join decision and beat-counter arithmetic for the beat being loaded this cycle.
    always_comb begin
        w_load    = w_x_avail && w_k_avail && (!r_m_valid || m_ready);
        w_xfer    = r_m_valid && m_ready;
        w_len_eff = r_len_q;
        if (r_beat_cnt == '0) begin
            // A new accumulation picks up the current configuration.
            w_len_eff = (cfg_k_len == '0) ? WL'(1) : cfg_k_len;
        end
        w_is_last   = (r_beat_cnt == (w_len_eff - WL'(1)));
        w_beat_next = w_is_last ? '0 : (r_beat_cnt + WL'(1));
    end

    // Output register: load a joined beat, or clear valid once the held beat leaves.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_mx      <= '0;
            r_mk      <= '0;
        end else if (w_load) begin
            r_m_valid <= 1'b1;
            r_m_last  <= w_is_last;
            r_mx      <= w_x_head[R*WX-1:0];
            r_mk      <= w_k_head[C*WK-1:0];
        end else if (w_xfer) begin
            r_m_valid <= 1'b0;
        end
    end

    // Beat counter and accumulation length, advanced on every loaded beat.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_beat_cnt <= '0;
            r_len_q    <= WL'(1);
        end else if (w_load) begin
            r_beat_cnt <= w_beat_next;
            if (r_beat_cnt == '0) begin
                r_len_q <= w_len_eff;
            end
        end
    end

    // One-cycle completion pulse following the transfer of a last beat.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_tile_done <= 1'b0;
        end else begin
            r_tile_done <= w_xfer && r_m_last;
        end
    end

`ifdef SA_FEEDER_LAST_CHECK_EN
    assign w_flag_err = (w_x_head[XW-1] != w_is_last) || (w_k_head[KW-1] != w_is_last);

    // Sticky flag: an input last marker disagreed with the counter on a loaded beat.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_err_last <= 1'b0;
        end else if (w_load && w_flag_err) begin
            r_err_last <= 1'b1;
        end
    end

    assign err_last = r_err_last;
`endif

    assign m_valid   = r_m_valid;
    assign m_last    = r_m_last;
    assign mx_data   = r_mx;
    assign mk_data   = r_mk;
    assign busy      = (r_beat_cnt != '0);
    assign tile_done = r_tile_done;

endmodule

// File: tb/tb_axis_sa_feeder.sv
// Self-checking bench for axis_sa_feeder: scoreboard of joined beats plus a reference
// accumulation counter for m_last / tile_done.
module tb_axis_sa_feeder;
    import axis_sa_pkg::*;

    localparam int R  = SA_R;
    localparam int C  = SA_C;
    localparam int WX = SA_WX;
    localparam int WK = SA_WK;
    localparam int WL = SA_WL;
    localparam int DW = R * WX + C * WK;

    // ---------------- clock / reset / DUT signals ----------------
    logic          clk       = 1'b0;
    logic          rstn      = 1'b0;
    logic [WL-1:0] cfg_k_len = 16'd4;
    logic          sx_valid  = 1'b0;
    logic          sk_valid  = 1'b0;
    logic          m_ready   = 1'b1;
    x_beat_t       sx_data   = '0;
    k_beat_t       sk_data   = '0;
    logic          sx_ready;
    logic          sk_ready;
    logic          m_valid;
    logic          m_last;
    logic          busy;
    logic          tile_done;
    x_beat_t       mx_data;
    k_beat_t       mk_data;
`ifdef SA_FEEDER_LAST_CHECK_EN
    logic          sx_last   = 1'b0;
    logic          sk_last   = 1'b0;
    logic          err_last;
    logic          flag_mode = 1'b0;
`endif

    always #5 clk = ~clk;

    axis_sa_feeder dut (
        .clk       (clk),
        .rstn      (rstn),
        .cfg_k_len (cfg_k_len),
        .sx_valid  (sx_valid),
        .sx_ready  (sx_ready),
        .sx_data   (sx_data),
        .sk_valid  (sk_valid),
        .sk_ready  (sk_ready),
        .sk_data   (sk_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .mx_data   (mx_data),
        .mk_data   (mk_data),
        .busy      (busy),
`ifdef SA_FEEDER_LAST_CHECK_EN
        .sx_last   (sx_last),
        .sk_last   (sk_last),
        .err_last  (err_last),
`endif
        .tile_done (tile_done)
    );

    // ---------------- scoreboard state ----------------
    int            checks   = 0;
    int            failures = 0;
    x_beat_t       x_q[$];
    k_beat_t       k_q[$];
    logic [DW-1:0] exp_q[$];
    x_beat_t       xs[64];
    k_beat_t       ks[64];
    int            x_acc, k_acc, n_xfer, run_lasts, run_td;
    int            cyc = 0;
    int            first_mv, first_pair;
    logic [63:0]   last_mask;
    int            m_cnt = 0;
    int            m_len = 1;
    logic          exp_td = 1'b0;
    logic          prev_stall = 1'b0;
    logic          prev_last;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] te;
    x_beat_t       tx;
    k_beat_t       tk;
    logic          ml;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, mid-cycle between input changes.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rstn) begin
            x_q.delete();
            k_q.delete();
            exp_q.delete();
            m_cnt      = 0;
            m_len      = 1;
            exp_td     = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check_eq("tile_done", 128'(tile_done), 128'(exp_td));
            if (prev_stall) begin
                check_eq("stall_valid", 128'(m_valid), 128'(1));
                check_eq("stall_data", 128'({mx_data, mk_data}), 128'(prev_data));
                check_eq("stall_last", 128'(m_last), 128'(prev_last));
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = {mx_data, mk_data};
            prev_last  = m_last;
            exp_td     = 1'b0;
            if (m_valid && m_ready) begin
                check_eq("pair_pending", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    te = exp_q.pop_front();
                    check_eq("beat_data", 128'({mx_data, mk_data}), 128'(te));
                end
                if (m_cnt == 0) m_len = (cfg_k_len == '0) ? 1 : int'(cfg_k_len);
                ml = (m_cnt == m_len - 1);
                m_cnt = ml ? 0 : m_cnt + 1;
                check_eq("m_last", 128'(m_last), 128'(ml));
                exp_td = ml;
                if (ml) begin
                    run_lasts++;
                    if (n_xfer < 64) last_mask[n_xfer] = 1'b1;
                end
                n_xfer++;
            end
            if (tile_done) run_td++;
            if (m_valid && first_mv < 0) first_mv = cyc;
            if (sx_valid && sx_ready) begin
                x_q.push_back(sx_data);
                x_acc++;
            end
            if (sk_valid && sk_ready) begin
                k_q.push_back(sk_data);
                k_acc++;
            end
            while (x_q.size() != 0 && k_q.size() != 0) begin
                tx = x_q.pop_front();
                tk = k_q.pop_front();
                exp_q.push_back({tx, tk});
                if (first_pair < 0) first_pair = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_run();
        x_acc = 0; k_acc = 0; n_xfer = 0; run_lasts = 0; run_td = 0;
        first_mv = -1; first_pair = -1; last_mask = '0;
        for (int i = 0; i < 64; i++) begin
            xs[i] = x_beat_t'($urandom);
            ks[i] = {$urandom, $urandom};
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Streams n beats; K starts k_delay cycles late; rdy_mode 1 drives m_ready 1,0,0,1.
    task automatic run_beats(input int n, input int k_delay, input int rdy_mode,
                             input int budget, input bit skew_chk);
        for (int c = 0; c <= budget; c++) begin
            @(posedge clk); #1;
            if (n_xfer >= n) break;
            if (skew_chk && c == 3) begin
                check_eq("skew_x_accepted", 128'(x_acc), 128'(2));
                check_eq("skew_sx_ready", 128'(sx_ready), 128'(0));
            end
            sx_valid = (x_acc < n);
            sx_data  = (x_acc < n) ? xs[x_acc] : '0;
            sk_valid = (c >= k_delay) && (k_acc < n);
            sk_data  = (k_acc < n) ? ks[k_acc] : '0;
`ifdef SA_FEEDER_LAST_CHECK_EN
            sx_last  = flag_mode && (x_acc == 2);
            sk_last  = flag_mode && (k_acc % 4 == 3);
`endif
            m_ready  = (rdy_mode == 1) ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
        end
        sx_valid = 1'b0;
        sk_valid = 1'b0;
        m_ready  = 1'b1;
        check_eq("run_complete", 128'(n_xfer), 128'(n));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 1'b0; sx_valid = 1'b0; sk_valid = 1'b0; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_m_valid", 128'(m_valid), 128'(0));
        check_eq("rst_m_last", 128'(m_last), 128'(0));
        check_eq("rst_busy", 128'(busy), 128'(0));
        check_eq("rst_tile_done", 128'(tile_done), 128'(0));
        check_eq("rst_data", 128'({mx_data, mk_data}), 128'(0));
        check_eq("rst_sx_ready", 128'(sx_ready), 128'(0));
        check_eq("rst_sk_ready", 128'(sk_ready), 128'(0));
        rstn = 1'b1;
        @(posedge clk); #1;
        check_eq("rel_sx_ready", 128'(sx_ready), 128'(1));
        check_eq("rel_sk_ready", 128'(sk_ready), 128'(1));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        do_reset();

        // 1) len 4, free flowing, 12 beats
        cfg_k_len = 16'd4;
        start_run();
        run_beats(12, 0, 0, 100, 1'b0);
        idle(3);
        check_eq("t1_last_mask", 128'(last_mask), 128'(64'h888));
        check_eq("t1_tile_done_cnt", 128'(run_td), 128'(3));
        check_eq("t1_latency", 128'(first_mv - first_pair), 128'(1));
        check_eq("t1_busy_end", 128'(busy), 128'(0));

        // 2) len 3, K four cycles late
        cfg_k_len = 16'd3;
        start_run();
        run_beats(6, 4, 0, 100, 1'b1);
        idle(2);
        check_eq("t2_last_mask", 128'(last_mask), 128'(64'h24));
        check_eq("t2_tile_done_cnt", 128'(run_td), 128'(2));

        // 3) len 5, output back-pressure 1,0,0,1
        cfg_k_len = 16'd5;
        start_run();
        run_beats(10, 0, 1, 200, 1'b0);
        idle(2);
        check_eq("t3_last_mask", 128'(last_mask), 128'(64'h210));
        check_eq("t3_tile_done_cnt", 128'(run_td), 128'(2));

        // 4) len 0 acts as 1; then 2 -> 6 change mid-accumulation
        cfg_k_len = 16'd0;
        start_run();
        run_beats(3, 0, 0, 50, 1'b0);
        idle(2);
        check_eq("t4_len0_mask", 128'(last_mask), 128'(64'h7));
        check_eq("t4_len0_busy", 128'(busy), 128'(0));
        cfg_k_len = 16'd2;
        start_run();
        run_beats(1, 0, 0, 50, 1'b0);
        idle(2);
        check_eq("t4_mid_mask", 128'(last_mask), 128'(0));
        check_eq("t4_mid_busy", 128'(busy), 128'(1));
        cfg_k_len = 16'd6;
        start_run();
        run_beats(7, 0, 0, 50, 1'b0);
        idle(2);
        check_eq("t4_switch_mask", 128'(last_mask), 128'(64'h41));
        check_eq("t4_switch_busy", 128'(busy), 128'(0));

        // 5) reset mid-accumulation with beats buffered
        cfg_k_len = 16'd4;
        start_run();
        run_beats(2, 0, 0, 50, 1'b0);
        idle(1);
        check_eq("t5_busy_before", 128'(busy), 128'(1));
        sx_valid = 1'b1; sk_valid = 1'b1; sx_data = xs[10]; sk_data = ks[10]; m_ready = 1'b0;
        idle(3);
        rstn = 1'b0; sx_valid = 1'b0; sk_valid = 1'b0; m_ready = 1'b1;
        @(posedge clk); #1;
        rstn = 1'b1;
        check_eq("t5_rst_m_valid", 128'(m_valid), 128'(0));
        check_eq("t5_rst_m_last", 128'(m_last), 128'(0));
        check_eq("t5_rst_busy", 128'(busy), 128'(0));
        check_eq("t5_rst_tile_done", 128'(tile_done), 128'(0));
        check_eq("t5_rst_data", 128'({mx_data, mk_data}), 128'(0));
        check_eq("t5_rst_sx_ready", 128'(sx_ready), 128'(0));
        @(posedge clk); #1;
        check_eq("t5_rel_sx_ready", 128'(sx_ready), 128'(1));
        check_eq("t5_rel_sk_ready", 128'(sk_ready), 128'(1));
        start_run();
        run_beats(4, 0, 0, 50, 1'b0);
        idle(2);
        check_eq("t5_last_mask", 128'(last_mask), 128'(64'h8));
        check_eq("t5_tile_done_cnt", 128'(run_td), 128'(1));

`ifdef SA_FEEDER_LAST_CHECK_EN
        // 6) wrong X last marker on beat 2 sets the sticky error
        do_reset();
        check_eq("t6_err_clear", 128'(err_last), 128'(0));
        flag_mode = 1'b1;
        cfg_k_len = 16'd4;
        start_run();
        run_beats(4, 0, 0, 50, 1'b0);
        flag_mode = 1'b0;
        sx_last = 1'b0;
        sk_last = 1'b0;
        idle(2);
        check_eq("t6_err_set", 128'(err_last), 128'(1));
        check_eq("t6_last_mask", 128'(last_mask), 128'(64'h8));
        idle(5);
        check_eq("t6_err_sticky", 128'(err_last), 128'(1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish (checks=%0d failures=%0d)", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
